// File: rtl/rx_session_controller_pkg.sv
// Shared definitions for the receive-session controller: FSM state encoding
// and the widths of the peak-identification result fields.
package rx_ctrl_pkg;

    localparam int PEAK_VAL_W  = 41;
    localparam int PEAK_SEQ_W  = 4;
    localparam int PEAK_TIME_W = 16;

    // Width of the settle counter; SETTLE_CYCLES is limited to 1..65535.
    localparam int SETTLE_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LISTEN = 2'd2,
        ST_REPORT = 2'd3
    } rx_state_e;

endpackage : rx_ctrl_pkg

// File: rtl/rx_session_controller_if.sv
// Session bus between ARM, peak identification and the receive-session
// controller. The controller connects through the slave modport.
interface rx_session_controller_if #(
    parameter int TIMER_W = 32
) ();
    import rx_ctrl_pkg::*;

    // ARM control
    logic                          istart;
    logic [TIMER_W-1:0]            itimeout;
    logic                          iabort;
    logic                          iresult_ack;

    // Peak identification results
    logic                          ipeak_trigger;
    logic signed [PEAK_VAL_W-1:0]  ipeak_value;
    logic [PEAK_SEQ_W-1:0]         ipeak_seq;
    logic [PEAK_TIME_W-1:0]        ipeak_time;

    // Controller outputs
    logic                          orx_en;
    logic                          osignal_trigg;
    logic                          opeak_ack;
    logic                          oresult_valid;
    logic signed [PEAK_VAL_W-1:0]  oresult_peak;
    logic [PEAK_SEQ_W-1:0]         oresult_seq;
    logic [PEAK_TIME_W-1:0]        oresult_time;
    logic                          otimed_out;
    logic                          obusy;

    modport slave (
        input  istart, itimeout, iabort, iresult_ack,
        input  ipeak_trigger, ipeak_value, ipeak_seq, ipeak_time,
        output orx_en, osignal_trigg, opeak_ack, oresult_valid,
        output oresult_peak, oresult_seq, oresult_time, otimed_out, obusy
    );

    modport master (
        output istart, itimeout, iabort, iresult_ack,
        output ipeak_trigger, ipeak_value, ipeak_seq, ipeak_time,
        input  orx_en, osignal_trigg, opeak_ack, oresult_valid,
        input  oresult_peak, oresult_seq, oresult_time, otimed_out, obusy
    );

endinterface : rx_session_controller_if

// File: rtl/rx_session_controller.sv
// Receive-session controller: one ranging session is
//   IDLE -> SETTLE (flush receive chain) -> LISTEN (timed window) -> REPORT.
// LISTEN ends on a peak result (detection) or when the window expires
// (timeout report with zeroed fields). ARM may abort at any time.
module rx_session_controller
    import rx_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 512,
    parameter int TIMER_W       = 32
) (
    input  logic                    crx_clk,
    input  logic                    rrx_rst_n,
    rx_session_controller_if.slave  bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [TIMER_W-1:0]  WIN_ONE     = TIMER_W'(1);

    rx_state_e                     state_q,      state_d;
    logic [SETTLE_W-1:0]           settle_cnt_q, settle_cnt_d;
    logic [TIMER_W-1:0]            win_cnt_q,    win_cnt_d;
    logic [TIMER_W-1:0]            timeout_q,    timeout_d;
    logic                          sig_trigg_q,  sig_trigg_d;
    logic                          peak_ack_q,   peak_ack_d;
    logic signed [PEAK_VAL_W-1:0]  res_peak_q,   res_peak_d;
    logic [PEAK_SEQ_W-1:0]         res_seq_q,    res_seq_d;
    logic [PEAK_TIME_W-1:0]        res_time_q,   res_time_d;
    logic                          timed_out_q,  timed_out_d;

    logic                          win_expired;

    // Window counter holds at all-ones instead of wrapping back to zero.
    function automatic logic [TIMER_W-1:0] win_sat_inc(input logic [TIMER_W-1:0] v);
        return (v == '1) ? v : v + WIN_ONE;
    endfunction

    // The latched timeout is never zero, so timeout-1 cannot underflow.
    assign win_expired = (win_cnt_q == (timeout_q - WIN_ONE));

    // Next-state, counter and report-field logic for the session FSM.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        win_cnt_d    = win_cnt_q;
        timeout_d    = timeout_q;
        sig_trigg_d  = 1'b0;
        peak_ack_d   = 1'b0;
        res_peak_d   = res_peak_q;
        res_seq_d    = res_seq_q;
        res_time_d   = res_time_q;
        timed_out_d  = timed_out_q;

        case (state_q)
            ST_IDLE: begin
                // A zero-length window is not a valid request.
                if (bus.istart && (bus.itimeout != '0)) begin
                    timeout_d    = bus.itimeout;
                    settle_cnt_d = '0;
                    win_cnt_d    = '0;
                    state_d      = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (bus.iabort) begin
                    state_d = ST_IDLE;
                end else begin
                    // Results arriving while the chain flushes are stale:
                    // acknowledge so peak identification can move on, drop them.
                    peak_ack_d = bus.ipeak_trigger;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d     = ST_LISTEN;
                        win_cnt_d   = '0;
                        sig_trigg_d = 1'b1;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SETTLE_ONE;
                    end
                end
            end

            ST_LISTEN: begin
                if (bus.iabort) begin
                    state_d = ST_IDLE;
                end else if (bus.ipeak_trigger) begin
                    // Detection wins over a coincident window expiry.
                    res_peak_d  = bus.ipeak_value;
                    res_seq_d   = bus.ipeak_seq;
                    res_time_d  = bus.ipeak_time;
                    timed_out_d = 1'b0;
                    peak_ack_d  = 1'b1;
                    state_d     = ST_REPORT;
                end else if (win_expired) begin
                    res_peak_d  = '0;
                    res_seq_d   = '0;
                    res_time_d  = '0;
                    timed_out_d = 1'b1;
                    state_d     = ST_REPORT;
                end else begin
                    win_cnt_d = win_sat_inc(win_cnt_q);
                end
            end

            ST_REPORT: begin
                if (bus.iabort || bus.iresult_ack) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, latched timeout, one-cycle pulses and report fields.
    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            timeout_q    <= '0;
            sig_trigg_q  <= 1'b0;
            peak_ack_q   <= 1'b0;
            res_peak_q   <= '0;
            res_seq_q    <= '0;
            res_time_q   <= '0;
            timed_out_q  <= 1'b0;
        end else begin
            settle_cnt_q <= settle_cnt_d;
            win_cnt_q    <= win_cnt_d;
            timeout_q    <= timeout_d;
            sig_trigg_q  <= sig_trigg_d;
            peak_ack_q   <= peak_ack_d;
            res_peak_q   <= res_peak_d;
            res_seq_q    <= res_seq_d;
            res_time_q   <= res_time_d;
            timed_out_q  <= timed_out_d;
        end
    end

    assign bus.orx_en        = (state_q == ST_SETTLE) || (state_q == ST_LISTEN);
    assign bus.obusy         = (state_q != ST_IDLE);
    assign bus.oresult_valid = (state_q == ST_REPORT);
    assign bus.osignal_trigg = sig_trigg_q;
    assign bus.opeak_ack     = peak_ack_q;
    assign bus.oresult_peak  = res_peak_q;
    assign bus.oresult_seq   = res_seq_q;
    assign bus.oresult_time  = res_time_q;
    assign bus.otimed_out    = timed_out_q;

endmodule : rx_session_controller

// File: tb/tb_rx_session_controller.sv
// Bench for rx_session_controller (SETTLE_CYCLES=8). Each session is
// described by its timing parameters; expected outputs for every cycle are
// derived from the session arithmetic (listen start, report start, ack
// cycles) relative to the cycle in which istart was accepted.
module tb_rx_session_controller;
    import rx_ctrl_pkg::*;

    localparam int S  = 8;
    localparam int TW = 32;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    logic signed [PEAK_VAL_W-1:0] prev_peak;
    logic [PEAK_SEQ_W-1:0]        prev_seq;
    logic [PEAK_TIME_W-1:0]       prev_time;
    logic                         prev_to;

    rx_session_controller_if #(.TIMER_W(TW)) bus ();

    rx_session_controller #(
        .SETTLE_CYCLES (S),
        .TIMER_W       (TW)
    ) dut (
        .crx_clk   (clk),
        .rrx_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx, input int k,
                                 input logic en, input logic busy, input logic valid,
                                 input logic strig, input logic ack,
                                 input logic signed [PEAK_VAL_W-1:0] pk,
                                 input logic [PEAK_SEQ_W-1:0] sq,
                                 input logic [PEAK_TIME_W-1:0] tm, input logic to);
        chk($sformatf("%s k=%0d orx_en", ctx, k),        64'(bus.orx_en),        64'(en));
        chk($sformatf("%s k=%0d obusy", ctx, k),         64'(bus.obusy),         64'(busy));
        chk($sformatf("%s k=%0d oresult_valid", ctx, k), 64'(bus.oresult_valid), 64'(valid));
        chk($sformatf("%s k=%0d osignal_trigg", ctx, k), 64'(bus.osignal_trigg), 64'(strig));
        chk($sformatf("%s k=%0d opeak_ack", ctx, k),     64'(bus.opeak_ack),     64'(ack));
        chk($sformatf("%s k=%0d oresult_peak", ctx, k),  64'(bus.oresult_peak),  64'(pk));
        chk($sformatf("%s k=%0d oresult_seq", ctx, k),   64'(bus.oresult_seq),   64'(sq));
        chk($sformatf("%s k=%0d oresult_time", ctx, k),  64'(bus.oresult_time),  64'(tm));
        chk($sformatf("%s k=%0d otimed_out", ctx, k),    64'(bus.otimed_out),    64'(to));
    endtask

    task automatic drive_noise();
        logic [63:0] rnd;
        rnd = {$urandom(), $urandom()};
        bus.ipeak_value = $signed(rnd[40:0]);
        bus.ipeak_seq   = 4'($urandom());
        bus.ipeak_time  = 16'($urandom());
    endtask

    task automatic drive_quiet();
        bus.istart        = 1'b0;
        bus.itimeout      = '0;
        bus.iabort        = 1'b0;
        bus.iresult_ack   = 1'b0;
        bus.ipeak_trigger = 1'b0;
        drive_noise();
    endtask

    // Idle cycles: stray triggers and (optionally) zero-timeout starts must not
    // wake the controller. Entered and left at posedge+1.
    task automatic idle_cycles(input string ctx, input int n, input bit zero_start);
        for (int k = 0; k < n; k++) begin
            drive_quiet();
            bus.istart        = zero_start;
            bus.itimeout      = '0;
            bus.ipeak_trigger = 1'($urandom_range(0, 1));
            bus.iresult_ack   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_outputs(ctx, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          prev_peak, prev_seq, prev_time, prev_to);
            @(posedge clk); #1;
        end
        drive_quiet();
    endtask

    // One complete session. strig_c: settle-phase trigger cycle (1..S) or -1.
    // ltrig_d: trigger offset from the first listen cycle or -1. A: cycles
    // between report start and iresult_ack.
    task automatic run_session(input string ctx, input int T, input int strig_c,
                               input int ltrig_d, input int A,
                               input logic signed [PEAK_VAL_W-1:0] val,
                               input logic [PEAK_SEQ_W-1:0] seq,
                               input logic [PEAK_TIME_W-1:0] tm,
                               input bit stray, input bit rst_in_report);
        int  L, R;
        bit  det;
        logic signed [PEAK_VAL_W-1:0] e_pk;
        logic [PEAK_SEQ_W-1:0]        e_sq;
        logic [PEAK_TIME_W-1:0]       e_tm;
        logic                         e_to;
        L   = 1 + S;
        det = (ltrig_d >= 0) && (ltrig_d < T);
        R   = det ? (L + ltrig_d + 1) : (L + T);
        for (int k = 0; k <= R + A + 1; k++) begin
            drive_quiet();
            bus.istart        = (k == 0) || (stray && (k == 3 || k == R));
            bus.itimeout      = (k == 0) ? TW'(T) : TW'($urandom_range(1, 200));
            bus.iresult_ack   = (k == R + A);
            bus.ipeak_trigger = (strig_c >= 1 && k == strig_c) ||
                                (det && k == L + ltrig_d) || (k == R);
            if (det && k == L + ltrig_d) begin
                bus.ipeak_value = val;
                bus.ipeak_seq   = seq;
                bus.ipeak_time  = tm;
            end
            @(negedge clk);
            if (k >= R) begin
                e_pk = det ? val : '0;
                e_sq = det ? seq : '0;
                e_tm = det ? tm  : '0;
                e_to = !det;
            end else begin
                e_pk = prev_peak;
                e_sq = prev_seq;
                e_tm = prev_time;
                e_to = prev_to;
            end
            check_outputs(ctx, k,
                          (k >= 1 && k < R),
                          (k >= 1 && k <= R + A),
                          (k >= R && k <= R + A),
                          (k == L),
                          ((strig_c >= 1 && k == strig_c + 1) || (det && k == R)),
                          e_pk, e_sq, e_tm, e_to);
            if (rst_in_report && k == R) begin
                #1 rst_n = 1'b0;
                #1;
                prev_peak = '0; prev_seq = '0; prev_time = '0; prev_to = 1'b0;
                check_outputs({ctx, " async-rst"}, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              '0, '0, '0, 1'b0);
                @(posedge clk); #1;
                check_outputs({ctx, " in-rst"}, k + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              '0, '0, '0, 1'b0);
                rst_n = 1'b1;
                drive_quiet();
                return;
            end
            @(posedge clk); #1;
        end
        drive_quiet();
        prev_peak = det ? val : '0;
        prev_seq  = det ? seq : '0;
        prev_time = det ? tm  : '0;
        prev_to   = !det;
    endtask

    // Session aborted in cycle ab_k (settle or listen); a trigger coincides
    // with the abort and must not be acknowledged.
    task automatic run_abort(input string ctx, input int T, input int ab_k);
        int L;
        L = 1 + S;
        for (int k = 0; k <= ab_k + 1; k++) begin
            drive_quiet();
            bus.istart        = (k == 0);
            bus.itimeout      = TW'(T);
            bus.iabort        = (k == ab_k);
            bus.ipeak_trigger = (k == ab_k);
            @(negedge clk);
            if (k <= ab_k)
                check_outputs(ctx, k, (k >= 1), (k >= 1), 1'b0, (k == L), 1'b0,
                              prev_peak, prev_seq, prev_time, prev_to);
            else
                check_outputs(ctx, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              prev_peak, prev_seq, prev_time, prev_to);
            @(posedge clk); #1;
        end
        drive_quiet();
    endtask

    initial begin
        int T, sc, ld, A, mode;
        logic [63:0] rnd;
        vectors     = 0;
        miscompares = 0;
        prev_peak = '0; prev_seq = '0; prev_time = '0; prev_to = 1'b0;
        rst_n = 1'b0;
        drive_quiet();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        rst_n = 1'b1;
        idle_cycles("post-reset idle", 3, 1'b0);

        // Zero-timeout start is ignored
        idle_cycles("zero-timeout start", 3, 1'b1);

        // Detection at cycle 30, timeout 100, stray starts in SETTLE/REPORT
        run_session("detect-100", 100, -1, 21, 3, 41'sd1234, 4'd5, 16'h0042, 1'b1, 1'b0);
        // Pure timeout after 20 listen cycles
        run_session("timeout-20", 20, -1, -1, 2, '0, '0, '0, 1'b0, 1'b0);
        // Stale trigger in settle cycle 3
        run_session("settle-trig", 12, 3, -1, 1, '0, '0, '0, 1'b0, 1'b0);
        // Trigger coincident with final window cycle
        run_session("trig-at-expiry", 15, -1, 14, 0, -41'sd77, 4'hA, 16'hBEEF, 1'b0, 1'b0);
        // Minimal windows and a trigger on the last settle cycle
        run_session("t1-detect", 1, S, 0, 0, 41'sd9, 4'h3, 16'h1234, 1'b0, 1'b0);
        run_session("t1-timeout", 1, -1, -1, 1, '0, '0, '0, 1'b1, 1'b0);

        // Abort in LISTEN and in SETTLE, each followed by a normal session
        run_abort("abort-listen", 30, 1 + S + 5);
        idle_cycles("after abort-listen", 2, 1'b0);
        run_session("post-abort", 10, -1, 4, 1, 41'sd555, 4'h7, 16'h0101, 1'b0, 1'b0);
        run_abort("abort-settle", 30, 4);
        run_session("post-abort2", 6, 2, -1, 0, '0, '0, '0, 1'b0, 1'b0);

        // Reset during REPORT, then a fresh start is required
        run_session("rst-report", 10, -1, 3, 5, 41'sd321, 4'h2, 16'h00FF, 1'b0, 1'b1);
        idle_cycles("after rst", 3, 1'b0);
        run_session("post-rst", 8, -1, 2, 2, -41'sd1, 4'hF, 16'hFFFF, 1'b1, 1'b0);

        // Randomized sessions
        for (int i = 0; i < 25; i++) begin
            T    = int'($urandom_range(1, 40));
            sc   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, S)) : -1;
            mode = int'($urandom_range(0, 2));
            ld   = (mode == 0) ? -1 : (mode == 1) ? int'($urandom_range(0, T - 1)) : T - 1;
            A    = int'($urandom_range(0, 4));
            rnd  = {$urandom(), $urandom()};
            run_session($sformatf("rand%0d", i), T, sc, ld, A, $signed(rnd[40:0]),
                        4'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 3) == 0)
                idle_cycles($sformatf("rand%0d idle", i), 1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rx_session_controller
